mem_burst_scheduler: RTL and testbench
======================================

MEM_BURST_SCHEDULER -- requirements
Module: mem_burst_scheduler

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4; maximum un-responded transactions per core, range 1..15.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: core_req  input  request_t[NUM_OF_CORES]  per-core request; held stable until accepted.
REQ-005 Port: core_ready  output  NUM_OF_CORES  one-cycle pulse on the final accepted beat of the granted core's burst.
REQ-006 Port: mem_req  output  request_t  request toward memory; all-zero when not in BURST.
REQ-007 Port: mem_ready  input  1  memory accepts the current mem_req beat.
REQ-008 Port: mem_rsp  input  request_t  response stream; vld plus core_id retires one transaction.
REQ-009 Port: grant_id  output  2  index of the granted core; 0 when idle.
REQ-010 Port: busy  output  1  high in BURST.
REQ-011 Port: err_flags  output  2  sticky; bit0 = response underflow, bit1 = burst timeout.

Function
REQ-012 FSM states: IDLE and BURST; reset state is IDLE.
REQ-013 Core i is eligible when core_req[i].vld is 1 and outstanding[i] < MAX_OUTSTANDING.
REQ-014 In IDLE with any core eligible, the FSM selects the first eligible core at or after rr_ptr (wrapping 3 to 0), registers grant_id and beat_cnt=0, and enters BURST next cycle.
REQ-015 In BURST, mem_req equals core_req[grant_id] combinationally.
REQ-016 In BURST, a beat is counted on each cycle with mem_ready=1.
REQ-017 Burst length is access_length beats; an access_length of 0 is treated as 1.
REQ-018 On the final beat, core_ready[grant_id] pulses, outstanding[grant_id] increments, rr_ptr becomes grant_id+1 mod 4, and the FSM returns to IDLE.
REQ-019 Minimum cost is one IDLE arbitration cycle per burst; back-to-back bursts are therefore separated by exactly one idle cycle.
REQ-020 If core_req[grant_id].vld drops during BURST, the burst aborts to IDLE next cycle, with no core_ready, no outstanding increment and rr_ptr unchanged.
REQ-021 A mem_rsp.vld with core_id c decrements outstanding[c] by 1.
REQ-022 If outstanding[c] is 0, the decrement is suppressed and err_flags[0] is set.
REQ-023 If an increment and a decrement hit the same core in the same cycle, outstanding is unchanged.
REQ-024 A mem_rsp core_id of 4 or more is ignored.
REQ-025 beat_cnt is 8 bits, matching the access_length width, and never wraps within a burst.

Reset
REQ-026 While reset=0, the following take these values: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, all outstanding=0, core_ready=0, mem_req=0, busy=0, err_flags=0.
REQ-027 Reset asserted mid-burst terminates the burst immediately; no core_ready is issued and no credit is retained.

Configuration
REQ-028 Macro MEM_SCHED_TIMEOUT_EN defined: a 9-bit stall counter counts consecutive BURST cycles with mem_ready=0.
REQ-029 With MEM_SCHED_TIMEOUT_EN defined, on reaching 256 the burst aborts to IDLE, err_flags[1] is set, and there is no credit and no core_ready.
REQ-030 Macro MEM_SCHED_TIMEOUT_EN undefined: no stall counter exists and err_flags[1] is tied to 0.

Structure
REQ-031 The shared package holds NUM_OF_CORES, request_t, the mem_sched_state_t enum and MEM_SCHED_TIMEOUT_CYCLES=256.
REQ-032 The round-robin selection is a combinational sub-module mem_sched_rr_pick: inputs eligible[3:0] and rr_ptr; outputs found and idx.

Verification
REQ-033 Scenario: core1 vld with access_length=3 and mem_ready=1 -> BURST for 3 cycles; core_ready[1] on the 3rd; outstanding[1]=1; rr_ptr=2.
REQ-034 Scenario: all 4 cores vld with access_length=1, rr_ptr=0 -> grant order 0,1,2,3,0 with one idle cycle between bursts.
REQ-035 Scenario: MAX_OUTSTANDING=2, core0 issues 2 bursts and receives no rsp -> core0 is skipped while core2 is granted; one mem_rsp for core0 makes it eligible again.
REQ-036 Scenario: mem_rsp for core3 with outstanding[3]=0 -> err_flags[0]=1 and the count stays at 0; a same-cycle grant completion plus rsp on core2 -> count unchanged.
REQ-037 Scenario: reset pulled low in beat 2 of a 5-beat burst -> all outputs are 0 asynchronously and the FSM restarts from IDLE.
REQ-038 Scenario: MEM_SCHED_TIMEOUT_EN with mem_ready held 0 for 256 cycles -> abort, err_flags[1]=1, core_ready never pulses.

Source files
------------

// File: rtl/mem_burst_scheduler_pkg.sv
// Shared types and constants for the memory burst scheduler.
// Request beats, FSM state encoding, and the burst-length helper.
package mem_burst_scheduler_pkg;

  localparam int NUM_OF_CORES             = 4;
  localparam int MEM_SCHED_TIMEOUT_CYCLES = 256;

  typedef struct packed {
    logic        vld;
    logic [2:0]  core_id;
    logic [7:0]  access_length;
    logic [31:0] addr;
  } request_t;

  typedef enum logic [0:0] {
    MS_IDLE  = 1'b0,
    MS_BURST = 1'b1
  } mem_sched_state_t;

  // A zero-length request still moves one beat.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/mem_burst_scheduler_if.sv
// Core/memory side bundle of the burst scheduler.
// master = scheduler view, slave = cores + memory view.
interface mem_burst_scheduler_if;
  import mem_burst_scheduler_pkg::*;

  request_t [NUM_OF_CORES-1:0] core_req;
  logic     [NUM_OF_CORES-1:0] core_ready;
  request_t                    mem_req;
  logic                        mem_ready;
  request_t                    mem_rsp;
  logic     [1:0]              grant_id;
  logic                        busy;
  logic     [1:0]              err_flags;

  modport master (
    input  core_req, mem_ready, mem_rsp,
    output core_ready, mem_req, grant_id, busy, err_flags
  );

  modport slave (
    output core_req, mem_ready, mem_rsp,
    input  core_ready, mem_req, grant_id, busy, err_flags
  );

endinterface

// File: rtl/mem_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr.
// No state, no latency.
module mem_sched_rr_pick (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic       found,
  output logic [1:0] idx
);

  always_comb begin
    logic [1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler: one core owns the memory port per burst, with per-core credit limit.
// MEM_SCHED_TIMEOUT_EN adds a 256-cycle mem_ready stall abort (err_flags[1]).
module mem_burst_scheduler
  import mem_burst_scheduler_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_burst_scheduler_if.master bus
);

  localparam logic [0:0] S_IDLE  = 1'(MS_IDLE);
  localparam logic [0:0] S_BURST = 1'(MS_BURST);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [0:0] r_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_grant_id;
  logic [7:0] r_beat_cnt;
  logic [3:0] r_outstanding [NUM_OF_CORES];
  logic       r_err_underflow;

  request_t                  w_gnt_req;
  logic                      w_busy;
  logic                      w_last_beat;
  logic                      w_done;
  logic                      w_timeout;
  logic                      w_err_timeout;
  logic [NUM_OF_CORES-1:0]   w_eligible;
  logic                      w_found;
  logic [1:0]                w_pick;
  logic [NUM_OF_CORES-1:0]   w_inc;
  logic [NUM_OF_CORES-1:0]   w_dec;
  logic                      w_underflow;
  logic [NUM_OF_CORES-1:0]   w_core_ready;
  logic                      w_unused_rsp;

  assign w_gnt_req   = bus.core_req[r_grant_id];
  assign w_busy      = (r_state == S_BURST);
  assign w_last_beat = w_gnt_req.vld && bus.mem_ready &&
                       (r_beat_cnt == eff_len(w_gnt_req.access_length) - 8'd1);
  assign w_done      = w_busy && w_last_beat;
  assign w_unused_rsp = ^{bus.mem_rsp.access_length, bus.mem_rsp.addr};

  always_comb begin
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      w_eligible[i] = bus.core_req[i].vld && (r_outstanding[i] < MAX_OUT);
    end
  end

  mem_sched_rr_pick u_rr_pick (
    .eligible (w_eligible),
    .rr_ptr   (r_rr_ptr),
    .found    (w_found),
    .idx      (w_pick)
  );

`ifdef MEM_SCHED_TIMEOUT_EN
  logic [8:0] r_stall;
  logic       r_err_timeout;

  // The 256th consecutive stalled cycle is the one that aborts.
  assign w_timeout = w_busy && w_gnt_req.vld && !bus.mem_ready &&
                     (r_stall == 9'(MEM_SCHED_TIMEOUT_CYCLES - 1));
  assign w_err_timeout = r_err_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_busy && !bus.mem_ready && !w_timeout) r_stall <= r_stall + 9'd1;
      else                                         r_stall <= '0;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign w_err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_BURST;
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        S_BURST: begin
          if (!w_gnt_req.vld || w_timeout) begin
            r_state <= S_IDLE;
          end else if (bus.mem_ready) begin
            if (w_last_beat) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= r_grant_id + 2'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A simultaneous completion and response on one core cancel out.
  always_comb begin
    w_underflow = 1'b0;
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      w_inc[i]    = w_done && (r_grant_id == 2'(i));
      w_dec[i]    = bus.mem_rsp.vld && (bus.mem_rsp.core_id == 3'(i));
      w_underflow = w_underflow |
                    (w_dec[i] && !w_inc[i] && (r_outstanding[i] == 4'd0));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OF_CORES; i++) r_outstanding[i] <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OF_CORES; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_outstanding[i] <= r_outstanding[i] + 4'd1;
        else if (w_dec[i] && !w_inc[i] && (r_outstanding[i] != 4'd0))
          r_outstanding[i] <= r_outstanding[i] - 4'd1;
      end
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

  always_comb begin
    w_core_ready = '0;
    if (w_done) w_core_ready[r_grant_id] = 1'b1;
  end

  assign bus.core_ready = w_core_ready;
  assign bus.mem_req    = w_busy ? w_gnt_req : '0;
  assign bus.grant_id   = w_busy ? r_grant_id : 2'd0;
  assign bus.busy       = w_busy;
  assign bus.err_flags  = {w_err_timeout, r_err_underflow};

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Bench for mem_burst_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_mem_burst_scheduler;
  import mem_burst_scheduler_pkg::*;

  localparam int MAXO = 2;
`ifdef MEM_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_burst_scheduler_if bus();

  mem_burst_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: a burst is "which core, how many beats still to go".
  bit   m_busy;
  int   m_g, m_left, m_rr, m_stall;
  int   m_out [4];
  bit   m_uf, m_to;
  logic [3:0] m_cr;

  logic [3:0] obs_cr;
  logic       obs_busy;
  logic [1:0] obs_gnt;
  logic [1:0] obs_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_left = 0; m_rr = 0; m_stall = 0;
    m_uf = 0; m_to = 0; m_cr = '0;
    for (int c = 0; c < 4; c++) m_out[c] = 0;
  endtask

  task automatic set_req(input int c, input bit v, input int len);
    request_t r;
    r.vld           = v;
    r.core_id       = 3'(c);
    r.access_length = 8'(len);
    r.addr          = $urandom;
    bus.core_req[c] = r;
  endtask

  task automatic set_rsp(input bit v, input int c);
    request_t r;
    r = '0;
    r.vld     = v;
    r.core_id = 3'(c);
    bus.mem_rsp = r;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 4; c++) bus.core_req[c] = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rsp   = '0;
  endtask

  task automatic model_update(input logic [3:0] cr);
    request_t g;
    bit       dec, hit;
    int       c;
    g = bus.core_req[m_g];
    if (m_busy) begin
      if (!g.vld) begin
        m_busy = 0;
      end else if (bus.mem_ready) begin
        m_stall = 0;
        if (m_left == 1) begin
          m_busy = 0;
          m_rr   = (m_g + 1) % 4;
        end else begin
          m_left--;
        end
      end else if (TO_EN) begin
        m_stall++;
        if (m_stall == MEM_SCHED_TIMEOUT_CYCLES) begin
          m_busy = 0;
          m_to   = 1;
        end
      end
    end else begin
      hit = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (!hit && bus.core_req[c].vld && m_out[c] < MAXO) begin
          hit     = 1;
          m_busy  = 1;
          m_g     = c;
          m_left  = (bus.core_req[c].access_length == 0) ? 1 : int'(bus.core_req[c].access_length);
          m_stall = 0;
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      dec = bus.mem_rsp.vld && (int'(bus.mem_rsp.core_id) == q);
      if (cr[q] && !dec)      m_out[q]++;
      else if (dec && !cr[q]) begin
        if (m_out[q] == 0) m_uf = 1;
        else               m_out[q]--;
      end
    end
  endtask

  // One clock: inputs are already driven just after a negedge.
  task automatic step();
    request_t   g, exp_req;
    logic [3:0] exp_cr;
    #1;
    g      = bus.core_req[m_g];
    exp_cr = '0;
    if (m_busy && g.vld && bus.mem_ready && m_left == 1) exp_cr[m_g] = 1'b1;
    exp_req = m_busy ? g : '0;
    chk("busy",       bus.busy,       m_busy);
    chk("grant_id",   bus.grant_id,   m_busy ? m_g : 0);
    chk("mem_req",    bus.mem_req,    exp_req);
    chk("core_ready", bus.core_ready, exp_cr);
    chk("err_flags",  bus.err_flags,  {m_to, m_uf});
    obs_cr   = bus.core_ready;
    obs_busy = bus.busy;
    obs_gnt  = bus.grant_id;
    obs_err  = bus.err_flags;
    m_cr     = exp_cr;
    model_update(exp_cr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit seen_cr;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    chk("rst_busy",    bus.busy,       0);
    chk("rst_grant",   bus.grant_id,   0);
    chk("rst_mem_req", bus.mem_req,    0);
    chk("rst_ready",   bus.core_ready, 0);
    chk("rst_err",     bus.err_flags,  0);

    // Core1, three beats, then round-robin pointer moves past core1.
    do_reset();
    set_req(1, 1, 3);
    bus.mem_ready = 1'b1;
    step(); chk("s33_idle", obs_busy, 0);
    step(); chk("s33_b1_busy", obs_busy, 1); chk("s33_b1_gnt", obs_gnt, 1); chk("s33_b1_cr", obs_cr, 0);
    step(); chk("s33_b2_cr", obs_cr, 0);
    step(); chk("s33_b3_cr", obs_cr, 4'b0010);
    set_req(1, 1, 1);
    set_req(2, 1, 1);
    step(); chk("s33_gap", obs_busy, 0);
    step(); chk("s33_rr_gnt", obs_gnt, 2); chk("s33_rr_cr", obs_cr, 4'b0100);

    // All cores, single beats: strict rotation with an idle cycle between.
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 1, 1);
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k % 2 == 0) chk("s34_gap", obs_busy, 0);
      else            chk("s34_gnt", obs_gnt, (k / 2) % 4);
    end

    // Credit limit: core0 saturates, core2 gets through, a response frees core0.
    do_reset();
    set_req(0, 1, 1);
    bus.mem_ready = 1'b1;
    repeat (4) step();
    set_req(2, 1, 1);
    step(); chk("s35_idle", obs_busy, 0);
    set_rsp(1, 0);
    step(); chk("s35_skip_gnt", obs_gnt, 2);
    set_rsp(0, 0);
    step();
    step(); chk("s35_back_gnt", obs_gnt, 0); chk("s35_back_busy", obs_busy, 1);

    // Underflow, out-of-range core_id ignored, count held at zero.
    do_reset();
    set_rsp(1, 5);
    step(); chk("s36_rst_err", obs_err, 0);
    set_rsp(1, 3);
    step(); chk("s36_id5_ignored", obs_err, 0);
    set_rsp(0, 0);
    set_req(3, 1, 1);
    bus.mem_ready = 1'b1;
    step(); chk("s36_uf_err", obs_err, 2'b01);
    step(); chk("s36_c3_gnt", obs_gnt, 3); chk("s36_c3_busy", obs_busy, 1);

    // Completion and response on the same core in one cycle.
    do_reset();
    set_req(2, 1, 1);
    bus.mem_ready = 1'b1;
    step();
    set_rsp(1, 2);
    step(); chk("s36b_cr", obs_cr, 4'b0100);
    set_req(2, 0, 0);
    step(); chk("s36b_no_uf", obs_err, 0);
    set_rsp(0, 0);
    step(); chk("s36b_uf_after", obs_err, 2'b01);

    // Reset in the middle of a five-beat burst.
    do_reset();
    set_req(0, 1, 5);
    bus.mem_ready = 1'b1;
    step();
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("s37_busy",    bus.busy,       0);
    chk("s37_grant",   bus.grant_id,   0);
    chk("s37_mem_req", bus.mem_req,    0);
    chk("s37_ready",   bus.core_ready, 0);
    chk("s37_err",     bus.err_flags,  0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(); chk("s37_restart_idle", obs_busy, 0);
    step(); chk("s37_restart_gnt", obs_busy, 1);

    // Memory stalls for a long time.
    do_reset();
    set_req(1, 1, 2);
    bus.mem_ready = 1'b0;
    seen_cr = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      seen_cr = seen_cr | (|obs_cr);
      if (k == 256) chk("to_busy_last", obs_busy, 1);
      if (k == 257) chk("to_abort", obs_busy, TO_EN ? 1'b0 : 1'b1);
    end
    chk("to_no_ready", seen_cr, 0);
    chk("to_err", obs_err[1], TO_EN);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (m_cr[c]) begin
          if ($urandom_range(0, 1) == 1) set_req(c, 1, $urandom_range(0, 4));
          else                           set_req(c, 0, 0);
        end else if (!bus.core_req[c].vld) begin
          if ($urandom_range(0, 2) == 0) set_req(c, 1, $urandom_range(0, 4));
        end else if ($urandom_range(0, 49) == 0) begin
          set_req(c, 0, 0);
        end
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      set_rsp($urandom_range(0, 2) == 0, $urandom_range(0, 5));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
